// File: rtl/serial_w_source_if.sv
// Handshake and serial-output bundle between a word producer and serial_w_source.
// The master modport is the serializer side; the slave modport is the side that loads words and consumes w.
interface serial_w_source_if #(
  parameter int WIDTH = 8
) ();
  logic             load;
  logic [WIDTH-1:0] data;
  logic             hold;
  logic             ready;
  logic             w;
  logic             w_valid;
  logic             done;

  modport master (
    input  load, data, hold,
    output ready, w, w_valid, done
  );

  modport slave (
    output load, data, hold,
    input  ready, w, w_valid, done
  );
endinterface

// File: rtl/serial_w_source.sv
// Serializes a WIDTH-bit word MSB first onto w, with hold stalls and GAP_CYCLES idle cycles after each word.
// Feeds the input w of a downstream sequence-detector FSM.
module serial_w_source #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input logic              Clock,
  input logic              Resetn,
  serial_w_source_if.master bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LOAD = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_r, next_state_s;
  logic [WIDTH-1:0] shreg_r, next_shreg_s;
  logic [CW-1:0]    cnt_r, next_cnt_s;
  logic [3:0]       gap_r, next_gap_s;
  logic             done_r, next_done_s;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= IDLE;
      shreg_r <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      gap_r   <= 4'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      shreg_r <= next_shreg_s;
      cnt_r   <= next_cnt_s;
      gap_r   <= next_gap_s;
      done_r  <= next_done_s;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    next_state_s = state_r;
    next_shreg_s = shreg_r;
    next_cnt_s   = cnt_r;
    next_gap_s   = gap_r;
    next_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.load) begin
          next_state_s = SHIFT;
          next_shreg_s = bus.data;
          next_cnt_s   = CNT_LAST;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (!bus.hold) begin
          next_shreg_s = shreg_r << 1;
          if (cnt_r == CNT_ZERO) begin
            next_done_s = 1'b1;
            next_cnt_s  = CNT_ZERO;
            if (GAP_CYCLES > 0) begin
              next_state_s = GAP;
              next_gap_s   = GAP_LOAD;
            end else begin
              next_state_s = IDLE;
              next_gap_s   = 4'd0;
            end
          end else begin
            next_cnt_s = cnt_r - CW'(1);
          end
        end else begin
          next_state_s = SHIFT;
        end
      end
      GAP: begin
        if (gap_r == 4'd0) begin
          next_state_s = IDLE;
        end else begin
          next_gap_s = gap_r - 4'd1;
        end
      end
      default: begin
        // Unused encoding recovers to a clean idle.
        next_state_s = IDLE;
        next_shreg_s = {WIDTH{1'b0}};
        next_cnt_s   = CNT_ZERO;
        next_gap_s   = 4'd0;
      end
    endcase
  end

  assign bus.ready   = (state_r == IDLE);
  assign bus.w       = (state_r == SHIFT) ? shreg_r[WIDTH-1] : 1'b0;
  assign bus.w_valid = (state_r == SHIFT) && !bus.hold;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_serial_w_source.sv
// Directed bench for serial_w_source: three instances (8-bit gap 1, 8-bit gap 0, 1-bit gap 1)
// compared every cycle against a bit-count model, plus hand-computed literal checks.
module tb_serial_w_source;

  logic Clock;
  logic Resetn;

  serial_w_source_if #(.WIDTH(8)) b0 ();
  serial_w_source_if #(.WIDTH(8)) b1 ();
  serial_w_source_if #(.WIDTH(1)) b2 ();

  serial_w_source #(.WIDTH(8), .GAP_CYCLES(1)) u0 (.Clock(Clock), .Resetn(Resetn), .bus(b0));
  serial_w_source #(.WIDTH(8), .GAP_CYCLES(0)) u1 (.Clock(Clock), .Resetn(Resetn), .bus(b1));
  serial_w_source #(.WIDTH(1), .GAP_CYCLES(1)) u2 (.Clock(Clock), .Resetn(Resetn), .bus(b2));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wid(input int i);
    return (i == 2) ? 1 : 8;
  endfunction

  function automatic int gap(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  logic        ld[3], hd[3], rdy[3], wo[3], vl[3], dn[3];
  logic [31:0] dt[3];

  assign ld[0] = b0.load; assign hd[0] = b0.hold; assign dt[0] = {24'd0, b0.data};
  assign ld[1] = b1.load; assign hd[1] = b1.hold; assign dt[1] = {24'd0, b1.data};
  assign ld[2] = b2.load; assign hd[2] = b2.hold; assign dt[2] = {31'd0, b2.data};
  assign rdy[0] = b0.ready; assign wo[0] = b0.w; assign vl[0] = b0.w_valid; assign dn[0] = b0.done;
  assign rdy[1] = b1.ready; assign wo[1] = b1.w; assign vl[1] = b1.w_valid; assign dn[1] = b1.done;
  assign rdy[2] = b2.ready; assign wo[2] = b2.w; assign vl[2] = b2.w_valid; assign dn[2] = b2.done;

  // Model: bits still to send, idle gap cycles left, the word in flight and the done pulse.
  int          rem[3];
  int          gl[3];
  logic [31:0] wd[3];
  logic        dm[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; gl[i] = 0; wd[i] = 32'd0; dm[i] = 1'b0;
    end
  end

  always @(posedge Clock or negedge Resetn) begin
    for (int i = 0; i < 3; i++) begin
      if (!Resetn) begin
        rem[i] <= 0;
        gl[i]  <= 0;
        dm[i]  <= 1'b0;
      end else begin
        dm[i] <= (rem[i] == 1) && !hd[i];
        if (rem[i] > 0) begin
          if (!hd[i]) begin
            rem[i] <= rem[i] - 1;
            if (rem[i] == 1) gl[i] <= gap(i);
          end
        end else if (gl[i] > 0) begin
          gl[i] <= gl[i] - 1;
        end else if (ld[i]) begin
          rem[i] <= wid(i);
          wd[i]  <= dt[i];
        end
      end
    end
  end

  // Received valid bits, newest in the LSB.
  logic [31:0] got[3];
  int          gotn[3];
  initial begin
    for (int i = 0; i < 3; i++) begin
      got[i] = 32'd0; gotn[i] = 0;
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge Clock) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model ready[%0d]", i), {31'd0, rdy[i]}, {31'd0, (rem[i] == 0 && gl[i] == 0)});
      chk($sformatf("model w_valid[%0d]", i), {31'd0, vl[i]}, {31'd0, (rem[i] > 0 && !hd[i])});
      chk($sformatf("model w[%0d]", i), {31'd0, wo[i]}, {31'd0, (rem[i] > 0) ? wd[i][rem[i]-1] : 1'b0});
      chk($sformatf("model done[%0d]", i), {31'd0, dn[i]}, {31'd0, dm[i]});
      if (vl[i]) begin
        got[i]  <= {got[i][30:0], wo[i]};
        gotn[i] <= gotn[i] + 1;
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  logic [7:0] pat;
  int         base;

  initial begin
    Resetn  = 1'b0;
    b0.load = 1'b0; b0.hold = 1'b0; b0.data = 8'h00;
    b1.load = 1'b0; b1.hold = 1'b0; b1.data = 8'h00;
    b2.load = 1'b0; b2.hold = 1'b0; b2.data = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset ready", {31'd0, b0.ready}, 32'd1);
    chk("reset w", {31'd0, b0.w}, 32'd0);
    chk("reset w_valid", {31'd0, b0.w_valid}, 32'd0);
    chk("reset done", {31'd0, b0.done}, 32'd0);
    Resetn = 1'b1;

    // Basic serialization of A5; load taken at the first edge after reset release.
    pat = 8'hA5;
    base = gotn[0];
    b0.data = 8'hA5; b0.load = 1'b1;
    step(); b0.load = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("basic w", {31'd0, b0.w}, {31'd0, pat[8-c]});
      chk("basic w_valid", {31'd0, b0.w_valid}, 32'd1);
      step();
    end
    chk("basic done c9", {31'd0, b0.done}, 32'd1);
    chk("basic ready c9", {31'd0, b0.ready}, 32'd0);
    step();
    chk("basic ready c10", {31'd0, b0.ready}, 32'd1);
    chk("basic done c10", {31'd0, b0.done}, 32'd0);
    chk("basic stream", got[0][7:0], 32'hA5);
    chk("basic bitcount", gotn[0] - base, 32'd8);

    // Hold during cycle 3.
    base = gotn[0];
    b0.data = 8'hA5; b0.load = 1'b1;
    step(); b0.load = 1'b0;
    step(); step();
    b0.hold = 1'b1;
    #1;
    chk("hold w_valid c3", {31'd0, b0.w_valid}, 32'd0);
    chk("hold w c3", {31'd0, b0.w}, 32'd1);
    step(); b0.hold = 1'b0;
    repeat (6) step();
    chk("hold done c10", {31'd0, b0.done}, 32'd1);
    step();
    chk("hold ready c11", {31'd0, b0.ready}, 32'd1);
    chk("hold stream", got[0][7:0], 32'hA5);
    chk("hold bitcount", gotn[0] - base, 32'd8);

    // Load of FF while busy in cycle 4 is ignored.
    base = gotn[0];
    b0.data = 8'hA5; b0.load = 1'b1;
    step(); b0.load = 1'b0;
    repeat (3) step();
    b0.data = 8'hFF; b0.load = 1'b1;
    #1;
    chk("busy ready c4", {31'd0, b0.ready}, 32'd0);
    step(); b0.load = 1'b0;
    chk("busy ready c5", {31'd0, b0.ready}, 32'd0);
    repeat (4) step();
    chk("busy done c9", {31'd0, b0.done}, 32'd1);
    step();
    chk("busy stream", got[0][7:0], 32'hA5);
    chk("busy bitcount", gotn[0] - base, 32'd8);

    // Reset in cycle 5 discards the word; the next word 3C is clean.
    b0.data = 8'hA5; b0.load = 1'b1;
    step(); b0.load = 1'b0;
    repeat (4) step();
    Resetn = 1'b0;
    #1;
    chk("rst mid w", {31'd0, b0.w}, 32'd0);
    chk("rst mid w_valid", {31'd0, b0.w_valid}, 32'd0);
    chk("rst mid ready", {31'd0, b0.ready}, 32'd1);
    chk("rst mid done", {31'd0, b0.done}, 32'd0);
    step(); Resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("rst no done", {31'd0, b0.done}, 32'd0);
    end
    base = gotn[0];
    b0.data = 8'h3C; b0.load = 1'b1;
    step(); b0.load = 1'b0;
    repeat (8) step();
    chk("rst next done c9", {31'd0, b0.done}, 32'd1);
    chk("rst next stream", got[0][7:0], 32'h3C);
    chk("rst next bitcount", gotn[0] - base, 32'd8);
    step();

    // Back-to-back with no gap: 80 then 01 loaded in the done cycle.
    base = gotn[1];
    b1.data = 8'h80; b1.load = 1'b1;
    step(); b1.load = 1'b0;
    chk("b2b w c1", {31'd0, b1.w}, 32'd1);
    repeat (8) step();
    chk("b2b done c9", {31'd0, b1.done}, 32'd1);
    chk("b2b ready c9", {31'd0, b1.ready}, 32'd1);
    b1.data = 8'h01; b1.load = 1'b1;
    step(); b1.load = 1'b0;
    repeat (7) step();
    chk("b2b w c17", {31'd0, b1.w}, 32'd1);
    chk("b2b w_valid c17", {31'd0, b1.w_valid}, 32'd1);
    step();
    chk("b2b done c18", {31'd0, b1.done}, 32'd1);
    chk("b2b stream", got[1][15:0], 32'h8001);
    chk("b2b bitcount", gotn[1] - base, 32'd16);

    // Single-bit words.
    base = gotn[2];
    b2.data = 1'b1; b2.load = 1'b1;
    step(); b2.load = 1'b0;
    chk("w1 w c1", {31'd0, b2.w}, 32'd1);
    chk("w1 w_valid c1", {31'd0, b2.w_valid}, 32'd1);
    step();
    chk("w1 done c2", {31'd0, b2.done}, 32'd1);
    chk("w1 w_valid c2", {31'd0, b2.w_valid}, 32'd0);
    step(); step();
    chk("w1 ready", {31'd0, b2.ready}, 32'd1);
    chk("w1 bitcount", gotn[2] - base, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_w_source.md
SERIAL_W_SOURCE -- requirements
Module: serial_w_source

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of bits per serialized word, legal range 1..32.
REQ-002 SHALL have parameter GAP_CYCLES, default 1: idle cycles inserted after each word, legal range 0..15.
REQ-003 SHALL have port Clock, input, 1: rising-edge clock for all state.
REQ-004 SHALL have port Resetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port load, input, 1: request to accept data this cycle.
REQ-006 SHALL have port data, input, WIDTH: parallel word to serialize, MSB first.
REQ-007 SHALL have port hold, input, 1: stall request while shifting.
REQ-008 SHALL have port ready, output, 1: block can accept a load this cycle.
REQ-009 SHALL have port w, output, 1: serial bit feeding the downstream sequence-detector FSM input w.
REQ-010 SHALL have port w_valid, output, 1: w carries a new bit this cycle.
REQ-011 SHALL have port done, output, 1: one-cycle pulse marking word completion.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, SHIFT, GAP; any unused encoding SHALL go to IDLE on the next edge.
REQ-013 SHALL drive ready=1 only in IDLE; combinational from state.
REQ-014 In IDLE, load=1 at a rising edge SHALL capture data into a WIDTH-bit shift register, set bit counter to WIDTH-1, and enter SHIFT.
REQ-015 load while ready=0 SHALL be ignored; shift register, counter, and state SHALL be unaffected.
REQ-016 In SHIFT, w SHALL equal the shift-register MSB; outside SHIFT, w SHALL be 0.
REQ-017 w_valid SHALL equal (state==SHIFT && hold==0).
REQ-018 In SHIFT with hold=0, each edge SHALL shift left by one, fill with 0, and decrement the counter.
REQ-019 In SHIFT with hold=1, shift register, counter, and state SHALL freeze, and w SHALL hold its value.
REQ-020 In SHIFT with hold=0 and counter==0, the edge SHALL leave SHIFT: to GAP if GAP_CYCLES>0, else to IDLE.
REQ-021 done SHALL be a registered one-cycle pulse, high in the cycle immediately after the last bit's valid cycle.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles with w=0, w_valid=0, ready=0, then enter IDLE.
REQ-023 hold SHALL have no effect in IDLE or GAP.
REQ-024 With GAP_CYCLES=0, a load in the done cycle (state IDLE) SHALL be accepted, giving back-to-back words with one idle cycle between last and first bit.
REQ-025 WIDTH=1 SHALL emit exactly one valid bit per load.

Reset
REQ-026 Resetn=0 SHALL immediately force state IDLE, shift register 0, counter 0, gap counter 0, and done=0, independent of Clock.
REQ-027 Resetn=0 SHALL immediately force outputs w=0, w_valid=0, done=0, ready=1.
REQ-028 Reset asserted mid-word SHALL discard the word; no done pulse SHALL follow.
REQ-029 The first load SHALL be accepted at the first rising edge after Resetn deasserts.

Verification
REQ-030 SHALL verify basic serialization (WIDTH=8, GAP=1): load 8'hA5 at edge 0 -> w=1,0,1,0,0,1,0,1 with w_valid=1 in cycles 1-8; done=1 and GAP in cycle 9; ready=1 in cycle 10.
REQ-031 SHALL verify back-to-back loads (GAP=0): load 8'h80 then 8'h01 in the done cycle -> w=1 in cycle 1 and w=1 in cycle 17; all other valid bits 0.
REQ-032 SHALL verify hold: 8'hA5 with hold=1 in cycle 3 -> w_valid=0 in cycle 3, w=1 held; bit sequence unchanged; done in cycle 10.
REQ-033 SHALL verify busy-load rejection: load=1 with data 8'hFF in cycle 4 of 8'hA5 -> stream still A5 and ready stays 0.
REQ-034 SHALL verify reset mid-word: Resetn=0 in cycle 5 -> same cycle w=0, w_valid=0, ready=1; no done pulse; next load 8'h3C serializes correctly.
REQ-035 SHALL verify WIDTH=1: load 1'b1 -> one cycle with w=1 and w_valid=1, then done the following cycle.
